spi_flash_arbiter: RTL and testbench
====================================

// Module: spi_flash_arbiter
// PURPOSE
// - Shares the single SPI flash pad group (cs_n, clk, sdat) between the Microwatt SPI flash controller (CPU) and the JTAG-side debug flash programmer (DBG).
// - Sits between microwatt_wrapper and the pads; grants the bus to one owner per transaction, never mid-transaction, with a guard gap on every hand-over.
// PARAMETERS
// - SDAT_W        1     flash data lanes (1 = single, 4 = quad)
// - GUARD_CYCLES  2     cycles of pads-idle between owners (>=1)
// - TIMEOUT       1024  cycles an idle owner (cs_n high, req high) may hold the bus while the other requests; 0 disables
// PORTS
// - ext_clk          in   1       system clock
// - ext_rst          in   1       asynchronous reset, active-low
// - cpu_req          in   1       CPU requests bus
// - cpu_gnt          out  1       CPU owns bus
// - cpu_cs_n         in   1       CPU chip select
// - cpu_clk          in   1       CPU SPI clock
// - cpu_sdat_o       in   SDAT_W  CPU data out
// - cpu_sdat_oe      in   SDAT_W  CPU data output enable (1 = drive)
// - cpu_sdat_i       out  SDAT_W  pad data to CPU
// - dbg_req/dbg_gnt/dbg_cs_n/dbg_clk/dbg_sdat_o/dbg_sdat_oe/dbg_sdat_i   same as cpu_* for DBG
// - pad_cs_n         out  1       to flash CS pad
// - pad_clk          out  1       to flash CLK pad
// - pad_sdat_o       out  SDAT_W  to data pads
// - pad_sdat_oe      out  SDAT_W  data pad drive enable (wrapper inverts for gpio_oeb)
// - pad_sdat_i       in   SDAT_W  from data pads
// - owner            out  2       00 none, 01 CPU, 10 DBG
// - timeout_evt      out  1       1-cycle pulse when a grant is revoked by TIMEOUT
// BEHAVIOUR
// - Reset (ext_rst low, async): state IDLE, guard/timeout counters 0, cpu_gnt=dbg_gnt=0, owner=00, timeout_evt=0, pad_cs_n=1, pad_clk=0, pad_sdat_o=0, pad_sdat_oe=0.
// - States: IDLE, OWN_CPU, OWN_DBG, GUARD. State, gnt, owner are registered; pad outputs are a combinational mux of owner inputs (zero-cycle data path).
// - IDLE: dbg_req -> OWN_DBG; else cpu_req -> OWN_CPU; DBG wins simultaneous requests. gnt rises the cycle after req is sampled (1-cycle latency).
// - OWN_x: pads follow x_* inputs; x_sdat_i = pad_sdat_i; non-owner sdat_i = 0.
// - Release: owner drops req while x_cs_n=1 -> GUARD. Drop of req while x_cs_n=0 is ignored until cs_n returns high (transaction completes; gnt held).
// - Timeout: owner req=1, x_cs_n=1, other req=1 -> counter increments; reaching TIMEOUT revokes: gnt=0, timeout_evt pulse, -> GUARD. Counter clears when x_cs_n=0 or other req=0. Never revokes with cs_n low.
// - GUARD: pads forced idle (cs_n=1, clk=0, sdat_o=0, oe=0), both gnt=0, owner=00 for exactly GUARD_CYCLES cycles; then re-arbitrate as IDLE, except the previous owner loses ties (alternation under contention).
// - Non-owner inputs never reach pads; a requester holding req during GUARD/other ownership simply waits.
// - Counter widths: $clog2(GUARD_CYCLES+1), $clog2(TIMEOUT+1); no wrap (saturating compare).
// - Reset mid-transaction: pads go idle immediately (async), owner lost; requesters must re-request.
// TESTING
// - Reset, cpu_req=1 -> cpu_gnt=1 next cycle, owner=01, pad_cs_n tracks cpu_cs_n same cycle.
// - cpu_req & dbg_req same cycle from IDLE -> dbg_gnt=1, cpu_gnt=0, pad_clk tracks dbg_clk only.
// - DBG drops req with dbg_cs_n=0 -> gnt held; cs_n high -> 2 guard cycles pads idle, owner=00 -> cpu_gnt=1.
// - TIMEOUT=16: CPU holds req, cs_n=1, dbg_req=1 -> revoke at 16th cycle, timeout_evt 1 cycle, dbg_gnt after 2 guard cycles.
// - Both requesting continuously, short transactions -> grants alternate DBG, CPU, DBG.
// - ext_rst low during DBG transfer (cs_n=0) -> pad_cs_n=1, oe=0 asynchronously; after release, arbitration restarts from IDLE.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// SPI flash pad arbiter: shares one flash pad group between the CPU flash
// controller and the debug flash programmer. The bus changes owner only
// between transactions (cs_n high), and every hand-over inserts a fixed run
// of pads-idle guard cycles. An idle owner that blocks a waiting requester
// can have its grant revoked after TIMEOUT cycles.
module spi_flash_arbiter #(
    parameter int SDAT_W       = 1,
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic              ext_clk,
    input  logic              ext_rst,

    input  logic              cpu_req,
    output logic              cpu_gnt,
    input  logic              cpu_cs_n,
    input  logic              cpu_clk,
    input  logic [SDAT_W-1:0] cpu_sdat_o,
    input  logic [SDAT_W-1:0] cpu_sdat_oe,
    output logic [SDAT_W-1:0] cpu_sdat_i,

    input  logic              dbg_req,
    output logic              dbg_gnt,
    input  logic              dbg_cs_n,
    input  logic              dbg_clk,
    input  logic [SDAT_W-1:0] dbg_sdat_o,
    input  logic [SDAT_W-1:0] dbg_sdat_oe,
    output logic [SDAT_W-1:0] dbg_sdat_i,

    output logic              pad_cs_n,
    output logic              pad_clk,
    output logic [SDAT_W-1:0] pad_sdat_o,
    output logic [SDAT_W-1:0] pad_sdat_oe,
    input  logic [SDAT_W-1:0] pad_sdat_i,

    output logic [1:0]        owner,
    output logic              timeout_evt
);

    localparam int G_W  = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Last guard cycle index, and the count at which an idle owner is revoked.
    localparam logic [G_W-1:0]  G_LAST     = G_W'((GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN_CPU = 2'd1,
        S_OWN_DBG = 2'd2,
        S_GUARD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [G_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            last_dbg_q, last_dbg_d;
    logic            timeout_evt_q, timeout_evt_d;

    // State, counters, tie-break memory and the revoke pulse.
    always_ff @(posedge ext_clk or negedge ext_rst) begin
        if (!ext_rst) begin
            state_q       <= S_IDLE;
            guard_cnt_q   <= '0;
            to_cnt_q      <= '0;
            last_dbg_q    <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            guard_cnt_q   <= guard_cnt_d;
            to_cnt_q      <= to_cnt_d;
            last_dbg_q    <= last_dbg_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    // Arbitration, release, timeout revoke and guard sequencing.
    always_comb begin
        state_d       = state_q;
        guard_cnt_d   = '0;
        to_cnt_d      = '0;
        last_dbg_d    = last_dbg_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbg_req) begin
                    state_d = S_OWN_DBG;
                end else if (cpu_req) begin
                    state_d = S_OWN_CPU;
                end
            end
            S_OWN_CPU: begin
                last_dbg_d = 1'b0;
                if (!cpu_req && cpu_cs_n) begin
                    state_d = S_GUARD;
                end else if (TIMEOUT_EN && cpu_req && cpu_cs_n && dbg_req) begin
                    if (to_cnt_q >= TO_LAST) begin
                        state_d       = S_GUARD;
                        timeout_evt_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_OWN_DBG: begin
                last_dbg_d = 1'b1;
                if (!dbg_req && dbg_cs_n) begin
                    state_d = S_GUARD;
                end else if (TIMEOUT_EN && dbg_req && dbg_cs_n && cpu_req) begin
                    if (to_cnt_q >= TO_LAST) begin
                        state_d       = S_GUARD;
                        timeout_evt_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (guard_cnt_q >= G_LAST) begin
                    // Previous owner loses a tie so contending masters alternate.
                    if (dbg_req && cpu_req) begin
                        state_d = last_dbg_q ? S_OWN_CPU : S_OWN_DBG;
                    end else if (dbg_req) begin
                        state_d = S_OWN_DBG;
                    end else if (cpu_req) begin
                        state_d = S_OWN_CPU;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_gnt     = (state_q == S_OWN_CPU);
    assign dbg_gnt     = (state_q == S_OWN_DBG);
    assign owner       = {dbg_gnt, cpu_gnt};
    assign timeout_evt = timeout_evt_q;

    // Zero-latency pad mux; anything but an owned state parks the pads idle.
    always_comb begin
        pad_cs_n    = 1'b1;
        pad_clk     = 1'b0;
        pad_sdat_o  = '0;
        pad_sdat_oe = '0;
        cpu_sdat_i  = '0;
        dbg_sdat_i  = '0;
        case (state_q)
            S_OWN_CPU: begin
                pad_cs_n    = cpu_cs_n;
                pad_clk     = cpu_clk;
                pad_sdat_o  = cpu_sdat_o;
                pad_sdat_oe = cpu_sdat_oe;
                cpu_sdat_i  = pad_sdat_i;
            end
            S_OWN_DBG: begin
                pad_cs_n    = dbg_cs_n;
                pad_clk     = dbg_clk;
                pad_sdat_o  = dbg_sdat_o;
                pad_sdat_oe = dbg_sdat_oe;
                dbg_sdat_i  = pad_sdat_i;
            end
            default: begin
                pad_cs_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed sequences with a scoreboard queue of
// expected owner/pad states (GUARD_CYCLES=2, TIMEOUT=16, quad lanes).
module tb_spi_flash_arbiter;

    localparam int SW = 4;

    logic          ext_clk = 1'b0;
    logic          ext_rst = 1'b0;
    logic          cpu_req = 1'b0, cpu_cs_n = 1'b1, cpu_clk = 1'b0;
    logic [SW-1:0] cpu_sdat_o = '0, cpu_sdat_oe = '0;
    logic          dbg_req = 1'b0, dbg_cs_n = 1'b1, dbg_clk = 1'b0;
    logic [SW-1:0] dbg_sdat_o = '0, dbg_sdat_oe = '0;
    logic [SW-1:0] pad_sdat_i = '0;
    logic          cpu_gnt, dbg_gnt, pad_cs_n, pad_clk, timeout_evt;
    logic [SW-1:0] cpu_sdat_i, dbg_sdat_i, pad_sdat_o, pad_sdat_oe;
    logic [1:0]    owner;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [1:0]    own;
        logic          evt;
        logic          cgnt;
        logic          dgnt;
        logic          cs_n;
        logic          clk;
        logic [SW-1:0] so;
        logic [SW-1:0] oe;
        logic [SW-1:0] csi;
        logic [SW-1:0] dsi;
    } exp_t;

    exp_t sb_q[$];

    spi_flash_arbiter #(
        .SDAT_W      (SW),
        .GUARD_CYCLES(2),
        .TIMEOUT     (16)
    ) dut (
        .ext_clk    (ext_clk),
        .ext_rst    (ext_rst),
        .cpu_req    (cpu_req),
        .cpu_gnt    (cpu_gnt),
        .cpu_cs_n   (cpu_cs_n),
        .cpu_clk    (cpu_clk),
        .cpu_sdat_o (cpu_sdat_o),
        .cpu_sdat_oe(cpu_sdat_oe),
        .cpu_sdat_i (cpu_sdat_i),
        .dbg_req    (dbg_req),
        .dbg_gnt    (dbg_gnt),
        .dbg_cs_n   (dbg_cs_n),
        .dbg_clk    (dbg_clk),
        .dbg_sdat_o (dbg_sdat_o),
        .dbg_sdat_oe(dbg_sdat_oe),
        .dbg_sdat_i (dbg_sdat_i),
        .pad_cs_n   (pad_cs_n),
        .pad_clk    (pad_clk),
        .pad_sdat_o (pad_sdat_o),
        .pad_sdat_oe(pad_sdat_oe),
        .pad_sdat_i (pad_sdat_i),
        .owner      (owner),
        .timeout_evt(timeout_evt)
    );

    always #5 ext_clk = ~ext_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Expected outputs for the given owner, built from the inputs now applied.
    task automatic push_exp(input logic [1:0] own, input logic evt);
        exp_t e;
        e      = '0;
        e.own  = own;
        e.evt  = evt;
        e.cgnt = (own == 2'b01);
        e.dgnt = (own == 2'b10);
        e.cs_n = 1'b1;
        if (own == 2'b01) begin
            e.cs_n = cpu_cs_n;  e.clk = cpu_clk;
            e.so   = cpu_sdat_o; e.oe = cpu_sdat_oe; e.csi = pad_sdat_i;
        end else if (own == 2'b10) begin
            e.cs_n = dbg_cs_n;  e.clk = dbg_clk;
            e.so   = dbg_sdat_o; e.oe = dbg_sdat_oe; e.dsi = pad_sdat_i;
        end
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_owner"},   32'(owner),       32'(e.own));
        check({tag, "_tevt"},    32'(timeout_evt), 32'(e.evt));
        check({tag, "_cpu_gnt"}, 32'(cpu_gnt),     32'(e.cgnt));
        check({tag, "_dbg_gnt"}, 32'(dbg_gnt),     32'(e.dgnt));
        check({tag, "_cs_n"},    32'(pad_cs_n),    32'(e.cs_n));
        check({tag, "_clk"},     32'(pad_clk),     32'(e.clk));
        check({tag, "_sdo"},     32'(pad_sdat_o),  32'(e.so));
        check({tag, "_oe"},      32'(pad_sdat_oe), 32'(e.oe));
        check({tag, "_cpu_si"},  32'(cpu_sdat_i),  32'(e.csi));
        check({tag, "_dbg_si"},  32'(dbg_sdat_i),  32'(e.dsi));
    endtask

    // Caller sets control inputs at posedge+1; data lanes are randomised here,
    // outputs sampled at posedge+4, then advance to the next posedge+1.
    task automatic step(input string tag, input logic [1:0] own, input logic evt);
        cpu_sdat_o  = SW'($urandom);
        cpu_sdat_oe = SW'($urandom);
        dbg_sdat_o  = SW'($urandom);
        dbg_sdat_oe = SW'($urandom);
        pad_sdat_i  = SW'($urandom);
        push_exp(own, evt);
        #3;
        pop_cmp(tag);
        @(posedge ext_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with busy-looking requester inputs: nothing reaches the pads.
        cpu_req = 1'b1; cpu_cs_n = 1'b0; cpu_clk = 1'b1;
        dbg_req = 1'b1; dbg_cs_n = 1'b0; dbg_clk = 1'b1;
        @(posedge ext_clk); #1;
        step("rst0", 2'b00, 1'b0);
        step("rst1", 2'b00, 1'b0);
        cpu_req = 1'b0; cpu_cs_n = 1'b1; cpu_clk = 1'b0;
        dbg_req = 1'b0; dbg_cs_n = 1'b1; dbg_clk = 1'b0;
        #2 ext_rst = 1'b1;
        @(posedge ext_clk); #1;

        // CPU alone: grant one cycle after request, pads track same cycle.
        cpu_req = 1'b1;
        step("a_req", 2'b00, 1'b0);
        cpu_cs_n = 1'b0; cpu_clk = 1'b1;
        step("a_own", 2'b01, 1'b0);
        cpu_clk = 1'b0; cpu_req = 1'b0;
        step("a_drop_csl", 2'b01, 1'b0);
        cpu_cs_n = 1'b1;
        step("a_csh", 2'b01, 1'b0);
        step("a_g0", 2'b00, 1'b0);
        step("a_g1", 2'b00, 1'b0);

        // Simultaneous request from IDLE: DBG wins.
        cpu_req = 1'b1; dbg_req = 1'b1;
        step("b_idle", 2'b00, 1'b0);
        dbg_req = 1'b0; dbg_cs_n = 1'b0; dbg_clk = 1'b1; cpu_clk = 1'b0;
        step("b_own1", 2'b10, 1'b0);
        dbg_clk = 1'b0; cpu_clk = 1'b1;
        step("b_own2", 2'b10, 1'b0);
        dbg_clk = 1'b1;
        step("b_hold", 2'b10, 1'b0);
        dbg_cs_n = 1'b1; dbg_clk = 1'b0;
        step("b_csh", 2'b10, 1'b0);
        step("b_g0", 2'b00, 1'b0);
        step("b_g1", 2'b00, 1'b0);

        // Idle CPU owner blocking DBG: revoked on the 16th blocking cycle.
        dbg_req = 1'b1;
        step("t_first", 2'b01, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cpu_clk = ~cpu_clk;
            step("t_hold", 2'b01, 1'b0);
        end
        step("t_revoke", 2'b00, 1'b1);
        step("t_g1", 2'b00, 1'b0);

        // Both keep requesting; short transactions: DBG, CPU, DBG.
        dbg_cs_n = 1'b0;
        step("c_dbg", 2'b10, 1'b0);
        dbg_cs_n = 1'b1; dbg_req = 1'b0;
        step("c_dbg_rel", 2'b10, 1'b0);
        dbg_req = 1'b1;
        step("c_g0", 2'b00, 1'b0);
        step("c_g1", 2'b00, 1'b0);
        cpu_cs_n = 1'b0;
        step("c_cpu", 2'b01, 1'b0);
        cpu_cs_n = 1'b1; cpu_req = 1'b0;
        step("c_cpu_rel", 2'b01, 1'b0);
        cpu_req = 1'b1;
        step("c_g2", 2'b00, 1'b0);
        step("c_g3", 2'b00, 1'b0);
        dbg_cs_n = 1'b0; dbg_clk = 1'b1;
        step("c_dbg2", 2'b10, 1'b0);
        step("c_dbg2b", 2'b10, 1'b0);

        // Asynchronous reset in the middle of a DBG transfer.
        #2 ext_rst = 1'b0;
        push_exp(2'b00, 1'b0);
        #1;
        pop_cmp("r_async");
        cpu_req = 1'b0; dbg_req = 1'b0; dbg_cs_n = 1'b1; dbg_clk = 1'b0;
        repeat (2) @(posedge ext_clk);
        #3 ext_rst = 1'b1;
        @(posedge ext_clk); #1;
        cpu_req = 1'b1;
        step("r_idle", 2'b00, 1'b0);
        step("r_cpu", 2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
